// File: rtl/branch_result_update_queue.sv
// branch_result_update_queue: multi-write, single-read FIFO draining resolved branches to predictor training
// Ports: clk/rst (sync, active-high); clear flushes everything, stall blocks enqueue;
// in_valid/in_is_ap_br/in_data are the per-lane brResult inputs; out_valid/out_ready/out_data drain the head;
// count is occupancy; drop_pulse/drop_count report entries lost to overflow (training is a hint, so drops are fine).
module branch_result_update_queue #(
    parameter int WIDTH   = 2,
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 96
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       stall,
    input  logic [WIDTH-1:0]           in_valid,
    input  logic [WIDTH-1:0]           in_is_ap_br,
    input  logic [WIDTH*ENTRY_W-1:0]   in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ENTRY_W-1:0]         out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop_pulse,
    output logic [15:0]                drop_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, widx;
    logic [CW-1:0] count_q, count_d, free, acc, drops;
    logic drop_pulse_q, drop_pulse_d, deq;
    logic [15:0] drop_count_q, drop_count_d;
    logic [16:0] dsum;
    assign out_valid  = count_q != '0;
    assign out_data   = mem_q[head_q];
    assign count      = count_q;
    assign drop_pulse = drop_pulse_q;
    assign drop_count = drop_count_q;
    // A same-cycle dequeue frees its slot; clear suppresses both enqueue and dequeue.
    always_comb begin
        deq = out_valid & out_ready & ~clear;
        free = CW'(DEPTH) - count_q + CW'(deq);
        mem_d = mem_q;
        acc = '0;
        drops = '0;
        widx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_valid[i] & ~in_is_ap_br[i] & ~stall & ~clear) begin
                if (acc < free) begin
                    widx = tail_q + acc[PW-1:0];
                    mem_d[widx] = in_data[i*ENTRY_W +: ENTRY_W];
                    acc = acc + CW'(1);
                end else begin
                    drops = drops + CW'(1);
                end
            end
        end
        dsum = {1'b0, drop_count_q} + 17'(drops);
        head_d = clear ? '0 : head_q + PW'(deq);
        tail_d = clear ? '0 : tail_q + acc[PW-1:0];
        count_d = clear ? '0 : count_q + acc - CW'(deq);
        drop_pulse_d = drops != '0;
        drop_count_d = dsum[16] ? 16'hFFFF : dsum[15:0];
    end
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
        end
    end
endmodule

// File: tb/tb_branch_result_update_queue.sv
// tb_branch_result_update_queue: directed vector table plus randomized run against a queue reference model
module tb_branch_result_update_queue;
    localparam int W = 2;
    localparam int D = 8;
    localparam int E = 96;
    logic clk = 1'b0, rst, clear, stall, out_ready, out_valid, drop_pulse;
    logic [W-1:0] in_valid, in_is_ap_br;
    logic [W*E-1:0] in_data;
    logic [E-1:0] out_data;
    logic [$clog2(D):0] count;
    logic [15:0] drop_count;
    int tests = 0, fails = 0;
    logic [E-1:0] mq[$];
    int mdc;
    logic mdp;
    typedef struct {
        logic r, c, s;
        logic [1:0] v, ap;
        logic [E-1:0] d0, d1;
        logic rdy;
        int cnt;
        logic ov;
        logic [E-1:0] od;
        logic dp;
        int dc;
    } vec_t;
    vec_t tbl[$];
    always #5 clk = ~clk;
    branch_result_update_queue #(.WIDTH(W), .DEPTH(D), .ENTRY_W(E)) dut (
        .clk(clk), .rst(rst), .clear(clear), .stall(stall),
        .in_valid(in_valid), .in_is_ap_br(in_is_ap_br), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .drop_pulse(drop_pulse), .drop_count(drop_count)
    );
    task automatic chk(string nm, logic [E-1:0] got, logic [E-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask
    // Check outputs against the model, advance the model by one cycle's rules, then clock.
    task automatic step();
        int drops = 0;
        chk("m_count", E'(count), E'(mq.size()));
        chk("m_valid", E'(out_valid), E'(mq.size() != 0));
        if (mq.size() != 0) chk("m_data", out_data, mq[0]);
        chk("m_dpulse", E'(drop_pulse), E'(mdp));
        chk("m_dcount", E'(drop_count), E'(mdc));
        if (rst) begin
            mq.delete();
            mdp = 1'b0;
            mdc = 0;
        end else if (clear) begin
            mq.delete();
            mdp = 1'b0;
        end else begin
            if (mq.size() != 0 && out_ready) void'(mq.pop_front());
            for (int i = 0; i < W; i++)
                if (in_valid[i] && !in_is_ap_br[i] && !stall) begin
                    if (mq.size() < D) mq.push_back(in_data[i*E +: E]);
                    else drops++;
                end
            mdp = drops != 0;
            mdc = (mdc + drops > 65535) ? 65535 : mdc + drops;
        end
        @(posedge clk);
        #1;
    endtask
    task automatic add(logic r, logic c, logic s, logic [1:0] v, logic [1:0] ap, logic [E-1:0] d0, logic [E-1:0] d1,
                       logic rdy, int cnt, logic ov, logic [E-1:0] od, logic dp, int dc);
        tbl.push_back('{r, c, s, v, ap, d0, d1, rdy, cnt, ov, od, dp, dc});
    endtask
    initial begin
        rst = 1'b1; clear = 1'b0; stall = 1'b0; out_ready = 1'b0;
        in_valid = '0; in_is_ap_br = '0; in_data = '0;
        @(posedge clk);
        #1;
        mq.delete(); mdp = 1'b0; mdc = 0;
        //  r  c  s  v      ap     d0     d1     rdy cnt ov od     dp dc
        add(1, 0, 0, 2'b11, 2'b00, 'h0,   'h0,   0,  0,  0, 'h0,   0, 0);
        add(0, 0, 0, 2'b11, 2'b00, 'hA,   'hB,   0,  2,  1, 'hA,   0, 0);
        add(0, 0, 0, 2'b00, 2'b00, 'h0,   'h0,   1,  1,  1, 'hB,   0, 0);
        add(0, 0, 0, 2'b00, 2'b00, 'h0,   'h0,   1,  0,  0, 'h0,   0, 0);
        add(0, 0, 0, 2'b11, 2'b00, 'h10,  'h11,  0,  2,  1, 'h10,  0, 0);
        add(0, 0, 0, 2'b11, 2'b00, 'h12,  'h13,  0,  4,  1, 'h10,  0, 0);
        add(0, 0, 0, 2'b11, 2'b00, 'h14,  'h15,  0,  6,  1, 'h10,  0, 0);
        add(0, 0, 0, 2'b01, 2'b00, 'h16,  'h0,   0,  7,  1, 'h10,  0, 0);
        add(0, 0, 0, 2'b11, 2'b00, 'h17,  'h18,  0,  8,  1, 'h10,  1, 1);
        add(0, 0, 0, 2'b11, 2'b00, 'h19,  'h1A,  1,  8,  1, 'h11,  1, 2);
        add(0, 0, 0, 2'b00, 2'b00, 'h0,   'h0,   0,  8,  1, 'h11,  0, 2);
        add(0, 0, 0, 2'b00, 2'b00, 'h0,   'h0,   1,  7,  1, 'h12,  0, 2);
        add(0, 0, 0, 2'b11, 2'b01, 'hBAD, 'hC,   0,  8,  1, 'h12,  0, 2);
        add(0, 0, 0, 2'b00, 2'b00, 'h0,   'h0,   1,  7,  1, 'h13,  0, 2);
        add(0, 0, 0, 2'b00, 2'b00, 'h0,   'h0,   1,  6,  1, 'h14,  0, 2);
        add(0, 0, 0, 2'b00, 2'b00, 'h0,   'h0,   1,  5,  1, 'h15,  0, 2);
        add(0, 1, 0, 2'b11, 2'b00, 'hDD,  'hEE,  1,  0,  0, 'h0,   0, 2);
        add(0, 0, 0, 2'b11, 2'b00, 'h20,  'h21,  0,  2,  1, 'h20,  0, 2);
        add(0, 0, 0, 2'b11, 2'b00, 'h22,  'h23,  0,  4,  1, 'h20,  0, 2);
        add(0, 0, 1, 2'b11, 2'b00, 'h24,  'h25,  1,  3,  1, 'h21,  0, 2);
        add(0, 0, 1, 2'b00, 2'b00, 'h0,   'h0,   1,  2,  1, 'h22,  0, 2);
        add(0, 0, 0, 2'b10, 2'b00, 'h0,   'h26,  0,  3,  1, 'h22,  0, 2);
        for (int k = 0; k < tbl.size(); k++) begin
            rst = tbl[k].r; clear = tbl[k].c; stall = tbl[k].s;
            in_valid = tbl[k].v; in_is_ap_br = tbl[k].ap;
            in_data = {tbl[k].d1, tbl[k].d0}; out_ready = tbl[k].rdy;
            step();
            chk($sformatf("v%0d_count", k), E'(count), E'(tbl[k].cnt));
            chk($sformatf("v%0d_valid", k), E'(out_valid), E'(tbl[k].ov));
            if (tbl[k].ov) chk($sformatf("v%0d_data", k), out_data, tbl[k].od);
            chk($sformatf("v%0d_dpulse", k), E'(drop_pulse), E'(tbl[k].dp));
            chk($sformatf("v%0d_dcount", k), E'(drop_count), E'(tbl[k].dc));
        end
        for (int n = 0; n < 400; n++) begin
            rst = (n == 200);
            clear = ($urandom_range(0, 39) == 0);
            stall = ($urandom_range(0, 7) == 0);
            in_valid = W'($urandom);
            in_is_ap_br = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            in_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            out_ready = $urandom_range(0, 99) < ((n % 100 < 50) ? 30 : 80);
            step();
        end
        rst = 1'b0; clear = 1'b0; stall = 1'b0; in_valid = '0; out_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("rst_count", E'(count), E'(0));
        chk("rst_valid", E'(out_valid), E'(0));
        chk("rst_dcount", E'(drop_count), E'(0));
        chk("rst_dpulse", E'(drop_pulse), E'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
